bloom_peak_mem: RTL and testbench
=================================

BLOOM_PEAK_MEM -- requirements
Module: bloom_peak_mem

Interface
REQ-001 Parameters SHALL be SIGNAL_WIDTH (default 18), the peak signal width.
REQ-002 DIST_WIDTH SHALL default to 14, the peak distance width.
REQ-003 PEAK_NUM SHALL default to 4, the peaks per entry.
REQ-004 NOT_WIDTH SHALL default to 2*PEAK_NUM, the notation bits per entry.
REQ-005 DATA_WIDTH SHALL default to (SIGNAL_WIDTH+DIST_WIDTH)*PEAK_NUM, the peak payload width.
REQ-006 ADDR_WIDTH SHALL default to 5 and MEM_LEN to 30, the entry count (MEM_LEN <= 2**ADDR_WIDTH).
REQ-007 The design has one clock and a synchronous, active-high reset; ports SHALL be clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-008 Load port SHALL be: ld_en in 1; ld_addr in ADDR_WIDTH; ld_data in DATA_WIDTH (payload write).
REQ-009 Read port SHALL be: rd_en in 1; rd_addr in ADDR_WIDTH; rd_valid out 1; rd_data out DATA_WIDTH; rd_not out NOT_WIDTH; rd_err out 1.
REQ-010 Notation-update port SHALL be: wr_en in 1; wr_addr in ADDR_WIDTH; wr_not in NOT_WIDTH; wr_mask in NOT_WIDTH; wr_mode in 1 (0 = masked overwrite, 1 = OR).
REQ-011 Control SHALL be: start in 1; bloom_end in 1; busy out 1; dump_valid out 1; dump_ready in 1; dump_data out NOT_WIDTH+DATA_WIDTH; dump_done out 1.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DUMP and DONE.
REQ-013 FSM transitions: IDLE->RUN on start; RUN->DUMP on bloom_end; DUMP->DONE after the last entry is accepted; DONE->IDLE when bloom_end is low.
REQ-014 ld_en SHALL be honoured only in IDLE and SHALL write the payload on the same rising edge.
REQ-015 rd_en and wr_en SHALL be honoured only in RUN and ignored in all other states.
REQ-016 Reads SHALL have 1-cycle latency: rd_valid, rd_data and rd_not correspond to the registered rd_addr one cycle after rd_en.
REQ-017 A notation write SHALL commit on the rising edge: each bit i with wr_mask[i]=1 becomes wr_not[i] (mode 0) or old|wr_not[i] (mode 1); unmasked bits are unchanged.
REQ-018 When wr_addr equals rd_addr in the same cycle, the read SHALL return the post-write notation (write-first bypass).
REQ-019 Any address >= MEM_LEN SHALL cause writes and loads to be dropped; a read at such an address returns zeros with rd_err=1 alongside rd_valid.
REQ-020 In DUMP, entries 0..MEM_LEN-1 SHALL be presented in order as dump_data={notation,payload} with dump_valid=1, advancing only on dump_valid&dump_ready.
REQ-021 dump_data SHALL hold stable while dump_valid=1 and dump_ready=0.
REQ-022 dump_done SHALL pulse for exactly 1 cycle on entry to DONE.
REQ-023 busy SHALL be 1 in DUMP and DONE.
REQ-024 Simultaneous start and bloom_end in IDLE SHALL resolve to RUN only.

Reset
REQ-025 rst SHALL force IDLE, clear all notation bits to 0, and drive rd_valid, rd_err, dump_valid, dump_done and busy to 0; the dump index SHALL reset to 0.
REQ-026 The payload array SHALL NOT be reset.
REQ-027 rst asserted mid-DUMP SHALL abort the dump with no further dump_valid.

Structure
REQ-028 The state enum and the entry-width helper constants SHALL live in a shared package, bloom_pkg.
REQ-029 The storage SHALL be one sub-module, bloom_entry_array, containing the payload and notation arrays with their write logic; the FSM, dump sequencer and read pipeline SHALL be in the top level.

Verification
REQ-030 Load entry 3 with 0xA5 pattern, start, read addr 3 -> next cycle rd_valid=1, rd_data=pattern, rd_not=0.
REQ-031 Write addr 7 with wr_not=8'hF0, mask=8'hFF, mode 0; then wr_not=8'h0F, mask=8'h0F, mode 1 -> read returns 8'hFF.
REQ-032 Read and write addr 2 in the same cycle with wr_not=8'h81 -> rd_not=8'h81.
REQ-033 Read addr 31 -> rd_err=1, data 0; write addr 30 -> no entry changes.
REQ-034 bloom_end with dump_ready toggling every other cycle -> 30 beats in order with stable data while stalled, then dump_done high for 1 cycle.
REQ-035 Assert rst at beat 10 of a dump -> dump_valid=0 next cycle, state IDLE, and all notations read 0 after restart.

Source files
------------

// File: rtl/bloom_pkg.sv
// Shared types and width helpers for the bloom peak memory.
package bloom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } bloom_state_t;

  localparam int DEF_SIGNAL_WIDTH = 18;
  localparam int DEF_DIST_WIDTH   = 14;
  localparam int DEF_PEAK_NUM     = 4;
  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_MEM_LEN      = 30;

  // Payload bits per entry: one signal and one distance field per peak.
  function automatic int payload_width(input int sig_w, input int dist_w, input int peaks);
    return (sig_w + dist_w) * peaks;
  endfunction

  // Notation bits per entry: two per peak.
  function automatic int notation_width(input int peaks);
    return 2 * peaks;
  endfunction

endpackage

// File: rtl/bloom_entry_array.sv
// Entry storage: unreset payload array plus resettable notation array,
// with an asynchronous read port for reads and one for the dump sequencer.
module bloom_entry_array
  import bloom_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_LEN    = DEF_MEM_LEN,
  parameter int DATA_WIDTH = payload_width(DEF_SIGNAL_WIDTH, DEF_DIST_WIDTH, DEF_PEAK_NUM),
  parameter int NOT_WIDTH  = notation_width(DEF_PEAK_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_commit,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  wr_commit,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [NOT_WIDTH-1:0]  wr_not,
  input  logic [NOT_WIDTH-1:0]  wr_mask,
  input  logic                  wr_mode,
  output logic [NOT_WIDTH-1:0]  wr_merged,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_payload,
  output logic [NOT_WIDTH-1:0]  rd_notation,
  input  logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_payload,
  output logic [NOT_WIDTH-1:0]  dump_notation
);

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_LEN);

  logic [DATA_WIDTH-1:0] payload  [MEM_LEN];
  logic [NOT_WIDTH-1:0]  notation [MEM_LEN];
  logic [NOT_WIDTH-1:0]  wr_old;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < MEM_LIMIT);
  endfunction

  // Merge a notation update into the current value of the addressed entry.
  always_comb begin
    wr_old    = '0;
    wr_merged = '0;
    if (addr_ok(wr_addr)) begin
      wr_old = notation[wr_addr];
    end else begin
      wr_old = '0;
    end
    wr_merged = (wr_old & ~wr_mask) | (wr_mask & (wr_mode ? (wr_old | wr_not) : wr_not));
  end

  // Guarded read ports; out-of-range addresses read as zero.
  always_comb begin
    rd_payload    = '0;
    rd_notation   = '0;
    dump_payload  = '0;
    dump_notation = '0;
    if (addr_ok(rd_addr)) begin
      rd_payload  = payload[rd_addr];
      rd_notation = notation[rd_addr];
    end else begin
      rd_payload  = '0;
      rd_notation = '0;
    end
    if (addr_ok(dump_addr)) begin
      dump_payload  = payload[dump_addr];
      dump_notation = notation[dump_addr];
    end else begin
      dump_payload  = '0;
      dump_notation = '0;
    end
  end

  // Payload write; the payload deliberately keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (ld_commit) begin
      payload[ld_addr] <= ld_data;
    end
  end

  // Notation write; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LEN; i++) begin
        notation[i] <= '0;
      end
    end else if (wr_commit) begin
      notation[wr_addr] <= wr_merged;
    end
  end

endmodule

// File: rtl/bloom_peak_mem.sv
// Bloom peak memory top: control FSM, dump sequencer and registered read path
// around the entry array.
module bloom_peak_mem
  import bloom_pkg::*;
#(
  parameter int SIGNAL_WIDTH = DEF_SIGNAL_WIDTH,
  parameter int DIST_WIDTH   = DEF_DIST_WIDTH,
  parameter int PEAK_NUM     = DEF_PEAK_NUM,
  parameter int NOT_WIDTH    = notation_width(PEAK_NUM),
  parameter int DATA_WIDTH   = payload_width(SIGNAL_WIDTH, DIST_WIDTH, PEAK_NUM),
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int MEM_LEN      = DEF_MEM_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_en,
  input  logic [ADDR_WIDTH-1:0]         ld_addr,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [NOT_WIDTH-1:0]          rd_not,
  output logic                          rd_err,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [NOT_WIDTH-1:0]          wr_not,
  input  logic [NOT_WIDTH-1:0]          wr_mask,
  input  logic                          wr_mode,
  input  logic                          start,
  input  logic                          bloom_end,
  output logic                          busy,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [NOT_WIDTH+DATA_WIDTH-1:0] dump_data,
  output logic                          dump_done
);

  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_LEN);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(MEM_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);

  bloom_state_t          state;
  bloom_state_t          next_state;
  logic [ADDR_WIDTH-1:0] dump_idx;
  logic                  dump_fire;
  logic                  ld_commit;
  logic                  wr_commit;
  logic                  rd_fire;
  logic [NOT_WIDTH-1:0]  wr_merged;
  logic [DATA_WIDTH-1:0] arr_rd_payload;
  logic [NOT_WIDTH-1:0]  arr_rd_notation;
  logic [NOT_WIDTH-1:0]  rd_not_fwd;
  logic [DATA_WIDTH-1:0] arr_dump_payload;
  logic [NOT_WIDTH-1:0]  arr_dump_notation;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < MEM_LIMIT);
  endfunction

  assign ld_commit = ld_en && (state == ST_IDLE) && addr_ok(ld_addr);
  assign wr_commit = wr_en && (state == ST_RUN) && addr_ok(wr_addr);
  assign rd_fire   = rd_en && (state == ST_RUN);
  assign dump_fire = dump_valid && dump_ready;
  assign dump_data = {arr_dump_notation, arr_dump_payload};

  bloom_entry_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_LEN    (MEM_LEN),
    .DATA_WIDTH (DATA_WIDTH),
    .NOT_WIDTH  (NOT_WIDTH)
  ) u_array (
    .clk           (clk),
    .rst           (rst),
    .ld_commit     (ld_commit),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .wr_commit     (wr_commit),
    .wr_addr       (wr_addr),
    .wr_not        (wr_not),
    .wr_mask       (wr_mask),
    .wr_mode       (wr_mode),
    .wr_merged     (wr_merged),
    .rd_addr       (rd_addr),
    .rd_payload    (arr_rd_payload),
    .rd_notation   (arr_rd_notation),
    .dump_addr     (dump_idx),
    .dump_payload  (arr_dump_payload),
    .dump_notation (arr_dump_notation)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start wins over bloom_end while idle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN; else next_state = ST_IDLE;
      ST_RUN:  if (bloom_end) next_state = ST_DUMP; else next_state = ST_RUN;
      ST_DUMP: if (dump_fire && (dump_idx == LAST_IDX)) next_state = ST_DONE; else next_state = ST_DUMP;
      ST_DONE: if (!bloom_end) next_state = ST_IDLE; else next_state = ST_DONE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy       = 1'b0;
    dump_valid = 1'b0;
    case (state)
      ST_DUMP: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
      end
      ST_DONE: begin
        busy       = 1'b1;
        dump_valid = 1'b0;
      end
      default: begin
        busy       = 1'b0;
        dump_valid = 1'b0;
      end
    endcase
  end

  // Dump index: advances on each accepted beat, parked at 0 outside DUMP.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_idx <= '0;
    end else if (state != ST_DUMP) begin
      dump_idx <= '0;
    end else if (dump_fire) begin
      dump_idx <= (dump_idx == LAST_IDX) ? '0 : (dump_idx + IDX_ONE);
    end
  end

  // One-cycle completion pulse on the DUMP to DONE transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_done <= 1'b0;
    end else begin
      dump_done <= (state == ST_DUMP) && (next_state == ST_DONE);
    end
  end

  // A same-cycle notation write to the read address is forwarded to the read.
  always_comb begin
    rd_not_fwd = arr_rd_notation;
    if (wr_commit && (wr_addr == rd_addr)) begin
      rd_not_fwd = wr_merged;
    end else begin
      rd_not_fwd = arr_rd_notation;
    end
  end

  // Registered read path with one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
      rd_not   <= '0;
    end else begin
      rd_valid <= rd_fire;
      rd_err   <= rd_fire && !addr_ok(rd_addr);
      if (rd_fire) begin
        rd_data <= arr_rd_payload;
        rd_not  <= rd_not_fwd;
      end
    end
  end

endmodule

// File: tb/tb_bloom_peak_mem.sv
// Scoreboard bench for bloom_peak_mem with default parameters.
module tb_bloom_peak_mem;

  localparam int AW = 5;
  localparam int DW = 128;
  localparam int NW = 8;
  localparam int ML = 30;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [NW-1:0] n;
    logic          e;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [NW-1:0] rd_not;
  logic          rd_err;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NW-1:0] wr_not;
  logic [NW-1:0] wr_mask;
  logic          wr_mode;
  logic          start;
  logic          bloom_end;
  logic          busy;
  logic          dump_valid;
  logic          dump_ready;
  logic [NW+DW-1:0] dump_data;
  logic          dump_done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_pay [ML];
  logic [NW-1:0] m_not [ML];
  rd_t exp_q[$];
  rd_t obs_q[$];

  bloom_peak_mem dut (
    .clk(clk), .rst(rst),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_not(rd_not), .rd_err(rd_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_not(wr_not), .wr_mask(wr_mask), .wr_mode(wr_mode),
    .start(start), .bloom_end(bloom_end), .busy(busy),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  // Collect every read result the DUT presents.
  always @(negedge clk) begin
    if (rd_valid) obs_q.push_back({rd_data, rd_not, rd_err});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One RUN-state cycle of read and/or notation write; updates the model and queues the expected read.
  task automatic drive_cycle(input logic r, input logic [AW-1:0] ra, input logic w,
                             input logic [AW-1:0] wa, input logic [NW-1:0] wn,
                             input logic [NW-1:0] wm, input logic wmd);
    rd_t e;
    rd_en = r; rd_addr = ra; wr_en = w; wr_addr = wa; wr_not = wn; wr_mask = wm; wr_mode = wmd;
    if (w && (int'(wa) < ML)) begin
      for (int b = 0; b < NW; b++) begin
        if (wm[b]) m_not[wa][b] = wmd ? (m_not[wa][b] | wn[b]) : wn[b];
      end
    end
    if (r) begin
      if (int'(ra) < ML) begin
        e.d = m_pay[ra]; e.n = m_not[ra]; e.e = 1'b0;
      end else begin
        e.d = '0; e.n = '0; e.e = 1'b1;
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_en = 0; ld_addr = '0; ld_data = '0; rd_en = 0; rd_addr = '0;
    wr_en = 0; wr_addr = '0; wr_not = '0; wr_mask = '0; wr_mode = 0;
    start = 0; bloom_end = 0; dump_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_valid, rd_err, dump_valid, dump_done, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {rd_valid, rd_err, dump_valid, dump_done, busy});
    end
    rst = 1'b0;
    for (int i = 0; i < ML; i++) m_not[i] = '0;
    @(negedge clk);
  endtask

  task automatic test_idle_load();
    logic [DW-1:0] v;
    for (int i = 0; i < ML; i++) begin
      v = (i == 3) ? {16{8'hA5}} : {$urandom, $urandom, $urandom, $urandom};
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = v; m_pay[i] = v;
      @(negedge clk);
    end
    ld_en = 1'b1; ld_addr = 5'd30; ld_data = '1;
    @(negedge clk);
    ld_en = 1'b0;
    rd_en = 1'b1; rd_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd5; wr_not = 8'hFF; wr_mask = 8'hFF;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_read_ignored: got rd_valid=%b expected 0", rd_valid);
    end
    start = 1'b1; bloom_end = 1'b1;
    @(negedge clk);
    start = 1'b0; bloom_end = 1'b0;
    checks++;
    if ({busy, dump_valid} !== 2'b00) begin
      errors++;
      $display("FAIL start_and_end_goes_run: got busy,dump_valid=%b expected 00", {busy, dump_valid});
    end
  endtask

  task automatic test_load_read();
    rd_t e, o;
    drive_cycle(1'b1, 5'd3, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    drive_cycle(1'b1, 5'd0, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    drive_cycle(1'b1, 5'd29, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    drive_cycle(1'b1, 5'd5, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL load_read_count: got %0d reads expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_read: got d=%h n=%h e=%b expected d=%h n=%h e=%b", o.d, o.n, o.e, e.d, e.n, e.e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_notation_rw();
    rd_t e, o;
    drive_cycle(1'b0, 5'd0, 1'b1, 5'd7, 8'hF0, 8'hFF, 1'b0);
    drive_cycle(1'b0, 5'd0, 1'b1, 5'd7, 8'h0F, 8'h0F, 1'b1);
    drive_cycle(1'b1, 5'd7, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    checks++;
    if (m_not[7] !== 8'hFF) begin
      errors++;
      $display("FAIL notation_model_addr7: got %h expected ff", m_not[7]);
    end
    for (int i = 0; i < ML; i++) begin
      drive_cycle(1'b0, 5'd0, 1'b1, AW'(i), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    for (int i = 0; i < ML; i++) begin
      drive_cycle(1'b0, 5'd0, 1'b1, AW'(i), 8'($urandom), 8'($urandom), 1'($urandom));
      drive_cycle(1'b1, AW'(i), 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL notation_count: got %0d reads expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL notation_read: got n=%h e=%b expected n=%h e=%b", o.n, o.e, e.n, e.e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    rd_t e, o;
    drive_cycle(1'b1, 5'd2, 1'b1, 5'd2, 8'h81, 8'hFF, 1'b0);
    for (int i = 0; i < ML; i++) begin
      drive_cycle(1'b1, AW'(i), 1'b1, AW'(i), 8'($urandom), 8'($urandom), 1'($urandom));
      drive_cycle(1'b1, AW'((i + 5) % ML), 1'b1, AW'(i), 8'($urandom), 8'($urandom), 1'b0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bypass_count: got %0d reads expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bypass_read: got d=%h n=%h expected d=%h n=%h", o.d, o.n, e.d, e.n);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_out_of_range();
    rd_t e, o;
    drive_cycle(1'b1, 5'd31, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    drive_cycle(1'b1, 5'd30, 1'b1, 5'd30, 8'hFF, 8'hFF, 1'b0);
    drive_cycle(1'b0, 5'd0, 1'b1, 5'd31, 8'hFF, 8'hFF, 1'b1);
    ld_en = 1'b1; ld_addr = 5'd0; ld_data = ~m_pay[0];
    @(negedge clk);
    ld_en = 1'b0;
    for (int i = 0; i < ML; i++) drive_cycle(1'b1, AW'(i), 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL range_count: got %0d reads expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL range_read: got d=%h n=%h e=%b expected d=%h n=%h e=%b", o.d, o.n, o.e, e.d, e.n, e.e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_dump();
    int beat = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic stalled = 1'b0;
    logic [NW+DW-1:0] last = '0;
    logic [NW+DW-1:0] want;
    bloom_end = 1'b1;
    @(negedge clk);
    bloom_end = 1'b0;
    dump_ready = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL dump_busy: got %b expected 1", busy);
    end
    while (beat < ML && cyc < 300) begin
      if (dump_valid) begin
        want = {m_not[beat], m_pay[beat]};
        checks++;
        if (dump_data !== want) begin
          errors++;
          $display("FAIL dump_beat_%0d: got %h expected %h", beat, dump_data, want);
        end
        if (stalled) begin
          checks++;
          if (dump_data !== last) begin
            errors++;
            $display("FAIL dump_stall_stable: got %h expected %h", dump_data, last);
          end
        end
        last = dump_data;
        dump_ready = ~dump_ready;
        stalled = ~dump_ready;
        if (dump_ready) beat++;
      end
      @(negedge clk);
      cyc++;
    end
    dump_ready = 1'b0;
    checks++;
    if (beat !== ML) begin
      errors++;
      $display("FAIL dump_beats: got %0d expected %0d", beat, ML);
    end
    checks++;
    if ({dump_valid, dump_done, busy} !== 3'b011) begin
      errors++;
      $display("FAIL dump_end_state: got valid,done,busy=%b expected 011", {dump_valid, dump_done, busy});
    end
    for (int k = 0; k < 5; k++) begin
      if (dump_done) done_cnt++;
      @(negedge clk);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL dump_done_width: got %0d cycles expected 1", done_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_dump_reset();
    rd_t e, o;
    logic [NW+DW-1:0] want;
    pulse_start();
    bloom_end = 1'b1;
    @(negedge clk);
    bloom_end = 1'b0;
    dump_ready = 1'b1;
    repeat (10) @(negedge clk);
    want = {m_not[10], m_pay[10]};
    checks++;
    if (dump_valid !== 1'b1 || dump_data !== want) begin
      errors++;
      $display("FAIL dump_beat10: got v=%b %h expected v=1 %h", dump_valid, dump_data, want);
    end
    rst = 1'b1; dump_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({dump_valid, busy, dump_done} !== 3'b000) begin
      errors++;
      $display("FAIL dump_abort: got valid,busy,done=%b expected 000", {dump_valid, busy, dump_done});
    end
    rst = 1'b0;
    for (int i = 0; i < ML; i++) m_not[i] = '0;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < ML; i++) drive_cycle(1'b1, AW'(i), 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL restart_count: got %0d reads expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL restart_read: got d=%h n=%h expected d=%h n=%h", o.d, o.n, e.d, e.n);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_load_read();
    test_notation_rw();
    test_back_to_back();
    test_out_of_range();
    test_dump();
    test_dump_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
